eb_skp_ctrl: RTL and testbench
==============================

EB_SKP_CTRL -- requirements
Module: eb_skp_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the elastic-buffer depth in words.
REQ-002 The block SHALL have parameter FILL_W, default 5, giving the fill-level width, equal to log2(DEPTH)+1.
REQ-003 The block SHALL have parameter HI_TH, default 12, the fill level at or above which a drop is needed.
REQ-004 The block SHALL have parameter LO_TH, default 4, the fill level at or below which an add is needed.
REQ-005 The block SHALL have parameter MID, default 8, the recentre target for hysteresis exit.
REQ-006 The block SHALL have parameter COOLDOWN, default 4, the minimum number of cycles between consecutive skp_add/skp_drop pulses.
REQ-007 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port fill_lvl, input, FILL_W bits: buffer occupancy already synchronised into the sys_clk domain.
REQ-010 The block SHALL have port rd_valid, input, 1 bit: the read side is consuming a word this cycle.
REQ-011 The block SHALL have port skp_slot, input, 1 bit: the current read word is a SKP symbol where add/drop is legal.
REQ-012 The block SHALL have port skp_add, output, 1 bit: one-cycle pulse requesting that a SKP be repeated.
REQ-013 The block SHALL have port skp_drop, output, 1 bit: one-cycle pulse requesting that a SKP be discarded.
REQ-014 The block SHALL have port state, output, 2 bits: FSM state encoded BAL=0, NEED_DROP=1, NEED_ADD=2.
REQ-015 The block SHALL have port ovf_err, output, 1 bit: sticky overflow flag.
REQ-016 The block SHALL have port unf_err, output, 1 bit: sticky underflow flag.
REQ-017 The block SHALL have port add_cnt, output, 16 bits: saturating count of skp_add pulses.
REQ-018 The block SHALL have port drop_cnt, output, 16 bits: saturating count of skp_drop pulses.

Function
REQ-019 The FSM SHALL go from BAL to NEED_DROP when fill_lvl >= HI_TH, and from BAL to NEED_ADD when fill_lvl <= LO_TH.
REQ-020 The FSM SHALL return from NEED_DROP to BAL when fill_lvl <= MID, and from NEED_ADD to BAL when fill_lvl >= MID.
REQ-021 The FSM SHALL go from NEED_ADD directly to NEED_DROP when fill_lvl >= HI_TH, and from NEED_DROP directly to NEED_ADD when fill_lvl <= LO_TH.
REQ-022 State transitions SHALL take effect on the sys_clk edge after fill_lvl is sampled (1-cycle latency).
REQ-023 An action SHALL be eligible in cycle N when skp_slot=1, rd_valid=1, the cooldown counter is 0, and state is NEED_DROP or NEED_ADD.
REQ-024 An eligible action in NEED_DROP SHALL produce a registered skp_drop=1 in cycle N+1 only.
REQ-025 An eligible action in NEED_ADD SHALL produce a registered skp_add=1 in cycle N+1 only.
REQ-026 skp_add and skp_drop SHALL never be high in the same cycle.
REQ-027 No action SHALL be taken in state BAL, regardless of skp_slot.
REQ-028 Each pulse SHALL load the cooldown counter with COOLDOWN, which then decrements each cycle to 0; skp_slot is ignored while the counter is nonzero.
REQ-029 With default parameters, pulses SHALL therefore be at least 5 cycles apart.
REQ-030 skp_slot with rd_valid=0 SHALL be ignored.
REQ-031 ovf_err SHALL set on the cycle after fill_lvl >= DEPTH, including any illegal value above DEPTH.
REQ-032 unf_err SHALL set on the cycle after fill_lvl == 0 with rd_valid=1.
REQ-033 ovf_err and unf_err SHALL both remain set until reset.
REQ-034 An error SHALL NOT suppress the FSM or pulse generation.
REQ-035 add_cnt and drop_cnt SHALL increment in the same cycle as their pulse.
REQ-036 add_cnt and drop_cnt SHALL hold at 16'hFFFF and never wrap.
REQ-037 All comparisons SHALL be unsigned at width FILL_W.
REQ-038 HI_TH > MID > LO_TH SHALL be guaranteed by the integrator and is not checked by the block.

Reset
REQ-039 While sys_rst=1 at a clock edge, the block SHALL set state=BAL, skp_add=0, skp_drop=0, cooldown counter=0, ovf_err=0, unf_err=0, add_cnt=0, drop_cnt=0.
REQ-040 Reset asserted mid-operation SHALL clear any pulse scheduled for the next cycle.
REQ-041 The first eligible action after reset deassertion SHALL require a fresh threshold crossing observed post-reset.

Verification
REQ-042 The bench SHALL drive fill_lvl=12, then skp_slot=1 and rd_valid=1 at cycle 3 -> state=1 at cycle 1, skp_drop=1 at cycle 4 only, drop_cnt=1.
REQ-043 The bench SHALL drive fill_lvl=3 with skp_slot=1 and rd_valid=1 every cycle for 12 cycles -> skp_add pulses exactly 5 cycles apart, skp_drop=0 throughout.
REQ-044 The bench SHALL drive fill_lvl 12 -> 10 -> 8 -> 13 -> state 1, 1, 0, 1, with no pulses while state=0.
REQ-045 The bench SHALL drive fill_lvl=16 for 1 cycle, then 8 -> ovf_err=1 and held, state eventually 0.
REQ-046 The bench SHALL drive fill_lvl=0 with rd_valid=1 -> unf_err=1; sys_rst=1 for 1 cycle -> all outputs 0.
REQ-047 The bench SHALL assert sys_rst in the cycle after an eligible skp_slot -> no skp_add/skp_drop pulse appears and counters stay 0.

Source files
------------

// File: rtl/eb_skp_ctrl.sv
// eb_skp_ctrl: elastic-buffer SKP add/drop controller with hysteresis, cooldown,
// sticky overflow/underflow flags and saturating pulse counters.
module eb_skp_ctrl #(
    parameter int DEPTH    = 16,
    parameter int FILL_W   = 5,
    parameter int HI_TH    = 12,
    parameter int LO_TH    = 4,
    parameter int MID      = 8,
    parameter int COOLDOWN = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [FILL_W-1:0] fill_lvl,
    input  logic              rd_valid,
    input  logic              skp_slot,
    output logic              skp_add,
    output logic              skp_drop,
    output logic [1:0]        state,
    output logic              ovf_err,
    output logic              unf_err,
    output logic [15:0]       add_cnt,
    output logic [15:0]       drop_cnt
);
    localparam int CD_W = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [FILL_W-1:0] HI_L  = FILL_W'(HI_TH);
    localparam logic [FILL_W-1:0] LO_L  = FILL_W'(LO_TH);
    localparam logic [FILL_W-1:0] MID_L = FILL_W'(MID);
    localparam logic [FILL_W-1:0] DEP_L = FILL_W'(DEPTH);

    typedef enum logic [1:0] {BAL = 2'd0, NEED_DROP = 2'd1, NEED_ADD = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            add_q, add_d, drop_q, drop_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic [15:0]     add_cnt_q, add_cnt_d, drop_cnt_q, drop_cnt_d;
    logic            hi, lo, act;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= BAL;
            cd_q       <= '0;
            add_q      <= 1'b0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            add_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cd_q       <= cd_d;
            add_q      <= add_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            add_cnt_q  <= add_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        hi      = fill_lvl >= HI_L;
        lo      = fill_lvl <= LO_L;
        state_d = state_q;
        case (state_q)
            BAL:       state_d = hi ? NEED_DROP : lo ? NEED_ADD : BAL;
            NEED_DROP: state_d = lo ? NEED_ADD : (fill_lvl <= MID_L) ? BAL : NEED_DROP;
            NEED_ADD:  state_d = hi ? NEED_DROP : (fill_lvl >= MID_L) ? BAL : NEED_ADD;
            default:   state_d = BAL;
        endcase
        // a slot is usable only once the previous pulse's cooldown has drained
        act        = skp_slot && rd_valid && cd_q == '0 && state_q != BAL;
        add_d      = act && state_q == NEED_ADD;
        drop_d     = act && state_q == NEED_DROP;
        cd_d       = act ? CD_W'(COOLDOWN) : (cd_q != '0 ? cd_q - 1'b1 : cd_q);
        ovf_d      = ovf_q | (fill_lvl >= DEP_L);
        unf_d      = unf_q | (fill_lvl == '0 && rd_valid);
        add_cnt_d  = add_cnt_q + {15'd0, add_d && add_cnt_q != 16'hFFFF};
        drop_cnt_d = drop_cnt_q + {15'd0, drop_d && drop_cnt_q != 16'hFFFF};
    end

    assign state    = state_q;
    assign skp_add  = add_q;
    assign skp_drop = drop_q;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;
    assign add_cnt  = add_cnt_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_eb_skp_ctrl.sv
// tb_eb_skp_ctrl: directed scenarios plus randomized traffic checked against a
// cycle-stamped behavioural model of the SKP controller.
module tb_eb_skp_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rd_valid = 1'b0;
    logic        skp_slot = 1'b0;
    logic [4:0]  fill_lvl = 5'd8;
    logic        skp_add, skp_drop, ovf_err, unf_err;
    logic [1:0]  state;
    logic [15:0] add_cnt, drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int m_state = 0, m_last = -1000, cyc = 0, m_addc = 0, m_dropc = 0;
    bit m_add = 0, m_drop = 0, m_ovf = 0, m_unf = 0;

    eb_skp_ctrl #(
        .DEPTH(16), .FILL_W(5), .HI_TH(12), .LO_TH(4), .MID(8), .COOLDOWN(4)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fill_lvl(fill_lvl),
        .rd_valid(rd_valid), .skp_slot(skp_slot), .skp_add(skp_add),
        .skp_drop(skp_drop), .state(state), .ovf_err(ovf_err),
        .unf_err(unf_err), .add_cnt(add_cnt), .drop_cnt(drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // m_last holds the cycle in which the last pulse was visible; actions are
    // allowed again COOLDOWN cycles after that
    task automatic model(input logic [4:0] f, input logic rv, input logic sl, input logic rs);
        bit elig;
        if (rs) begin
            m_state = 0; m_add = 0; m_drop = 0; m_ovf = 0; m_unf = 0;
            m_addc = 0; m_dropc = 0; m_last = -1000;
        end else begin
            elig   = sl && rv && m_state != 0 && (cyc - m_last >= 4);
            m_add  = elig && m_state == 2;
            m_drop = elig && m_state == 1;
            if (elig) m_last = cyc + 1;
            if (m_add && m_addc < 65535) m_addc++;
            if (m_drop && m_dropc < 65535) m_dropc++;
            if (f >= 12 && m_state != 1) m_state = 1;
            else if (f <= 4 && m_state != 2) m_state = 2;
            else if (m_state == 1 && f <= 8) m_state = 0;
            else if (m_state == 2 && f >= 8) m_state = 0;
            m_ovf = m_ovf | (f >= 16);
            m_unf = m_unf | (f == 0 && rv);
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("skp_add", skp_add, m_add);
        chk("skp_drop", skp_drop, m_drop);
        chk("ovf_err", ovf_err, m_ovf);
        chk("unf_err", unf_err, m_unf);
        chk("add_cnt", add_cnt, m_addc);
        chk("drop_cnt", drop_cnt, m_dropc);
    endtask

    task automatic step(input logic [4:0] f, input logic rv, input logic sl, input logic rs);
        fill_lvl = f; rd_valid = rv; skp_slot = sl; sys_rst = rs;
        @(posedge sys_clk);
        model(f, rv, sl, rs);
        #1;
        check_all();
    endtask

    initial begin
        int pulses[$];
        int drops;
        logic [4:0] f;
        step(5'd8, 0, 0, 1);
        step(5'd8, 0, 0, 1);
        chk("rst_state", state, 0);
        chk("rst_pulses", {skp_add, skp_drop}, 0);
        chk("rst_flags", {ovf_err, unf_err}, 0);
        chk("rst_cnts", {add_cnt, drop_cnt}, 0);

        step(5'd12, 0, 0, 0);
        chk("drop_seq_state_c1", state, 1);
        step(5'd12, 0, 0, 0);
        step(5'd12, 0, 0, 0);
        step(5'd12, 1, 1, 0);
        chk("drop_seq_pulse_c4", skp_drop, 1);
        chk("drop_seq_cnt", drop_cnt, 1);
        step(5'd12, 0, 0, 0);
        chk("drop_seq_pulse_c5", skp_drop, 0);

        step(5'd8, 0, 0, 1);
        drops = 0;
        for (int i = 0; i < 12; i++) begin
            step(5'd3, 1, 1, 0);
            if (skp_add) pulses.push_back(i);
            if (skp_drop) drops++;
        end
        chk("add_train_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            chk("add_gap_1", pulses[1] - pulses[0], 5);
            chk("add_gap_2", pulses[2] - pulses[1], 5);
        end
        chk("add_train_no_drop", drops, 0);

        step(5'd8, 0, 0, 1);
        step(5'd12, 1, 1, 0);
        chk("hyst_s12", state, 1);
        step(5'd10, 1, 1, 0);
        chk("hyst_s10", state, 1);
        step(5'd8, 1, 1, 0);
        chk("hyst_s8", state, 0);
        step(5'd13, 1, 1, 0);
        chk("hyst_s13_state", state, 1);
        chk("hyst_bal_no_pulse", {skp_add, skp_drop}, 0);
        step(5'd8, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(5'd10, 1, 1, 0);
        chk("bal_idle_cnts", {add_cnt, drop_cnt}, 0);

        step(5'd16, 0, 0, 0);
        step(5'd8, 0, 0, 0);
        step(5'd8, 0, 0, 0);
        step(5'd8, 0, 0, 0);
        chk("ovf_held", ovf_err, 1);
        chk("ovf_state_bal", state, 0);

        step(5'd0, 1, 0, 0);
        chk("unf_set", unf_err, 1);
        step(5'd8, 0, 0, 1);
        chk("post_rst_all", {state, skp_add, skp_drop, ovf_err, unf_err, add_cnt, drop_cnt}, 0);

        step(5'd3, 0, 0, 0);
        chk("pre_abort_state", state, 2);
        step(5'd3, 1, 1, 1);
        chk("abort_no_pulse", {skp_add, skp_drop}, 0);
        chk("abort_cnts", {add_cnt, drop_cnt}, 0);
        step(5'd3, 1, 1, 0);
        chk("fresh_cross_no_pulse", skp_add, 0);
        step(5'd3, 1, 1, 0);
        chk("fresh_cross_pulse", skp_add, 1);

        for (int i = 0; i < 400; i++) begin
            f = ($urandom_range(0, 39) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 16));
            step(f, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
